// File: rtl/loop3_out_drain_if.sv
// Handshake bundle between the loop3 accumulator, the drain block and the
// downstream byte-beat consumer.
interface loop3_out_drain_if #(
  parameter int NUM_LANES  = 64,
  parameter int BEAT_LANES = 16
);
  logic [NUM_LANES*16-1:0] loop3_regdata;
  logic                    loop3_regdata_v;
  logic                    halt_out;
  logic [BEAT_LANES*8-1:0] out_data;
  logic                    out_v;
  logic                    out_ready;
  logic                    out_last;
  logic                    overflow_err;

  // drain block side
  modport slave (
    input  loop3_regdata, loop3_regdata_v, out_ready,
    output halt_out, out_data, out_v, out_last, overflow_err
  );

  // upstream/downstream side
  modport master (
    output loop3_regdata, loop3_regdata_v, out_ready,
    input  halt_out, out_data, out_v, out_last, overflow_err
  );
endinterface

// File: rtl/loop3_out_drain.sv
// loop3 output drain: requantises 64 signed 16b accumulator lanes to int8
// (optional ReLU, round-half-up shift, saturate) and streams them out as
// four 16-byte beats with ready/valid handshake and upstream halt.

// Per-lane requantiser: ReLU -> round -> arithmetic shift -> saturate.
module loop3_lane #(
  parameter int SHIFT   = 8,
  parameter int RELU_EN = 1
) (
  input  logic [15:0] acc,
  output logic [7:0]  q
);
  // (1<<SHIFT)>>1 is 2^(SHIFT-1) for SHIFT>0 and 0 for SHIFT=0.
  localparam logic signed [16:0] RND = 17'((1 << SHIFT) >> 1);

  logic signed [16:0] v;
  logic signed [16:0] r;

  // Lane arithmetic in 17b so the rounding add cannot wrap.
  always_comb begin
    v = {acc[15], acc};
    if (RELU_EN != 0 && acc[15]) v = '0;
    r = (v + RND) >>> SHIFT;
    if (r > 17'sd127)        q = 8'h7f;
    else if (r < -17'sd128)  q = 8'h80;
    else                     q = r[7:0];
  end
endmodule

module loop3_out_drain #(
  parameter int SHIFT      = 8,
  parameter int RELU_EN    = 1,
  parameter int NUM_LANES  = 64,
  parameter int BEAT_LANES = 16
) (
  input logic             clk,
  input logic             rst,
  loop3_out_drain_if.slave io
);
  localparam int         BEATS     = NUM_LANES / BEAT_LANES;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic       ovf_q;
  logic [BEATS-1:0][BEAT_LANES-1:0][7:0] buf_q;
  logic [NUM_LANES-1:0][7:0]             proc;

  logic xfer, last_xfer, accept, drop;

  // One requantiser per accumulator lane.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    loop3_lane #(.SHIFT(SHIFT), .RELU_EN(RELU_EN)) u_lane (
      .acc (io.loop3_regdata[16*g +: 16]),
      .q   (proc[g])
    );
  end

  // Handshake decode: a new vector may only enter when idle or when the
  // final beat leaves this very cycle (gives gap-free back-to-back vectors).
  always_comb begin
    xfer      = (state_q == SEND) && io.out_ready;
    last_xfer = xfer && (beat_q == LAST_BEAT);
    accept    = io.loop3_regdata_v && ((state_q == IDLE) || last_xfer);
    drop      = io.loop3_regdata_v && !accept;
  end

  // Next-state / beat counter.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (accept) begin
      state_d = SEND;
      beat_d  = '0;
    end else if (xfer) begin
      beat_d = beat_q + 2'd1;
      if (beat_q == LAST_BEAT) state_d = IDLE;
    end
  end

  // State register; reset aborts any in-flight vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Vector buffer and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) buf_q <= proc;
      if (drop)   ovf_q <= 1'b1;
    end
  end

  // Outputs; halt releases only when the last beat is being taken.
  assign io.out_v        = (state_q == SEND);
  assign io.out_last     = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign io.halt_out     = (state_q == SEND) && !(beat_q == LAST_BEAT && io.out_ready);
  assign io.out_data     = buf_q[beat_q];
  assign io.overflow_err = ovf_q;
endmodule

// File: tb/tb_loop3_out_drain.sv
// Bench for loop3_out_drain: three parameterisations driven by common
// stimulus, compared each cycle against a transaction-level model.
module tb_loop3_out_drain;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] data;
  logic          v;
  logic          ready;

  logic [ND-1:0]        o_v, o_last, o_halt, o_ovf;
  logic [ND-1:0][127:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // d=0: SHIFT 8 ReLU on; d=1: SHIFT 8 ReLU off; d=2: SHIFT 0 ReLU off
  for (genvar g = 0; g < ND; g++) begin : g_dut
    loop3_out_drain_if ifc ();
    loop3_out_drain #(.SHIFT((g == 2) ? 0 : 8), .RELU_EN((g == 0) ? 1 : 0)) dut (
      .clk (clk),
      .rst (rst),
      .io  (ifc.slave)
    );
    assign ifc.loop3_regdata   = data;
    assign ifc.loop3_regdata_v = v;
    assign ifc.out_ready       = ready;
    assign o_v[g]    = ifc.out_v;
    assign o_last[g] = ifc.out_last;
    assign o_halt[g] = ifc.halt_out;
    assign o_ovf[g]  = ifc.overflow_err;
    assign o_data[g] = ifc.out_data;
  end

  // ---- reference model ----
  bit         m_busy;
  int         m_beat;
  bit         m_ovf;
  logic [7:0] m_vec [ND][64];

  function automatic int sh_of(int d);
    return (d == 2) ? 0 : 8;
  endfunction

  function automatic bit relu_of(int d);
    return d == 0;
  endfunction

  function automatic logic [7:0] ref_lane(int x, int sh, bit relu);
    int y;
    y = x;
    if (relu && y < 0) y = 0;
    if (sh > 0) y = (y + (1 << (sh - 1))) >>> sh;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  function automatic logic [127:0] exp_beat(int d);
    logic [127:0] e;
    for (int j = 0; j < 16; j++) e[8*j +: 8] = m_vec[d][16*m_beat + j];
    return e;
  endfunction

  task automatic model_step();
    bit xf, acc;
    if (!rst) begin
      m_busy = 0; m_beat = 0; m_ovf = 0;
      for (int d = 0; d < ND; d++) for (int i = 0; i < 64; i++) m_vec[d][i] = 8'h00;
    end else begin
      xf  = m_busy && ready;
      acc = v && (!m_busy || (xf && m_beat == 3));
      if (v && !acc) m_ovf = 1;
      if (acc) begin
        for (int d = 0; d < ND; d++)
          for (int i = 0; i < 64; i++)
            m_vec[d][i] = ref_lane(int'($signed(data[16*i +: 16])), sh_of(d), relu_of(d));
        m_busy = 1;
        m_beat = 0;
      end else if (xf) begin
        if (m_beat == 3) begin
          m_busy = 0;
          m_beat = 0;
        end else m_beat++;
      end
    end
  endtask

  // ---- checking ----
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT to the model, clock once, advance the model.
  task automatic step();
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("out_v[%0d]", d), 128'(o_v[d]), 128'(m_busy));
      chk($sformatf("out_last[%0d]", d), 128'(o_last[d]), 128'(m_busy && m_beat == 3));
      chk($sformatf("halt[%0d]", d), 128'(o_halt[d]), 128'(m_busy && !(m_beat == 3 && ready)));
      chk($sformatf("ovf[%0d]", d), 128'(o_ovf[d]), 128'(m_ovf));
      if (m_busy) chk($sformatf("data[%0d] b%0d", d, m_beat), o_data[d], exp_beat(d));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 5))
        0:       data[16*i +: 16] = 16'h7fff;
        1:       data[16*i +: 16] = 16'h8000;
        2:       data[16*i +: 16] = 16'($signed($urandom_range(0, 600)) - 300);
        default: data[16*i +: 16] = 16'($urandom);
      endcase
    end
  endtask

  task automatic send_rand();
    rand_data();
    v = 1'b1;
    step();
    v = 1'b0;
  endtask

  initial begin
    logic [15:0] pat [4];
    pat[0] = 16'h7fff; pat[1] = 16'h8000; pat[2] = 16'hff80; pat[3] = 16'h007f;
    rst = 1'b0; v = 1'b0; ready = 1'b1; data = '0;
    @(negedge clk);
    run(2);
    #1;
    chk("rst_data", o_data[0], 128'h0);
    chk("rst_halt", 128'(o_halt[0]), 128'h0);
    rst = 1'b1;

    // basic path
    for (int i = 0; i < 64; i++) data[16*i +: 16] = 16'h0280;
    v = 1'b1; step(); v = 1'b0;
    #1 chk("basic_b0", o_data[0], {16{8'h03}});
    run(5);

    // saturation / ReLU
    for (int i = 0; i < 64; i++) data[16*i +: 16] = pat[i % 4];
    v = 1'b1; step(); v = 1'b0;
    #1;
    chk("sat_relu", o_data[0], {4{32'h0000007f}});
    chk("sat_norelu", o_data[1], {4{32'h0000807f}});
    run(5);

    // backpressure during beat 2
    send_rand();
    run(2);
    ready = 1'b0; run(5);
    ready = 1'b1; run(4);

    // back-to-back
    send_rand();
    run(3);
    send_rand();
    #1 chk("b2b_ovf", 128'(o_ovf[0]), 128'h0);
    run(5);

    // drop during beat 1
    send_rand();
    run(1);
    send_rand();
    #1 chk("drop_ovf", 128'(o_ovf[0]), 128'h1);
    run(5);

    // reset mid-vector
    send_rand();
    run(2);
    rst = 1'b0; step(); rst = 1'b1;
    #1;
    chk("rstmid_v", 128'(o_v[0]), 128'h0);
    chk("rstmid_ovf", 128'(o_ovf[0]), 128'h0);
    send_rand();
    run(5);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) != 0);
      v     = ($urandom_range(0, 9) < 3);
      ready = ($urandom_range(0, 9) < 7);
      if (v) rand_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
